// File: rtl/irq_aggregator.sv
// Interrupt concentrator: synchronises NUM_SRC sources, applies edge/level mode,
// enable and pending state, and presents them on the 31-bit processor IRQ vector.
module irq_aggregator #(
   parameter int unsigned        NUM_SRC      = 8,
   parameter int unsigned        SYNC_STAGES  = 2,
   parameter logic [NUM_SRC-1:0] MODE_DEFAULT = '0
) (
   input  logic               CLK,
   input  logic               RESETN,
   input  logic [NUM_SRC-1:0] SRC_IRQ,
   input  logic               PSEL,
   input  logic               PENABLE,
   input  logic               PWRITE,
   input  logic [7:0]         PADDR,
   input  logic [31:0]        PWDATA,
   output logic [31:0]        PRDATA,
   output logic               PREADY,
   output logic               PSLVERR,
   output logic [30:0]        IRQ_OUT,
   output logic               IRQ_ANY
);

   localparam logic [5:0] REG_ENABLE  = 6'h00;
   localparam logic [5:0] REG_MODE    = 6'h01;
   localparam logic [5:0] REG_PENDING = 6'h02;
   localparam logic [5:0] REG_RAW     = 6'h03;
   localparam logic [5:0] REG_FORCE   = 6'h04;

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] s;
   logic [NUM_SRC-1:0] hist_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] enable_q;
   logic [NUM_SRC-1:0] mode_q;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] pend_d;
   logic [NUM_SRC-1:0] wdata;
   logic [NUM_SRC-1:0] set_bits;
   logic [NUM_SRC-1:0] w1c_bits;
   logic [NUM_SRC-1:0] mode_chg;
   logic [30:0]        irq_d;
   logic [31:0]        rdata;
   logic               access;
   logic               wr;
   logic               hit;
   logic [5:0]         word;
   logic               unused_bits;

   assign s           = sync_q[SYNC_STAGES-1];
   assign rise        = s & ~hist_q;
   assign access      = PSEL & PENABLE;
   assign wr          = access & PWRITE;
   assign word        = PADDR[7:2];
   assign wdata       = PWDATA[NUM_SRC-1:0];
   assign PREADY      = 1'b1;
   assign unused_bits = ^{PADDR[1:0], PWDATA[31:NUM_SRC]};

   always_comb begin
      hit   = 1'b1;
      rdata = '0;
      case (word)
         REG_ENABLE:  rdata[NUM_SRC-1:0] = enable_q;
         REG_MODE:    rdata[NUM_SRC-1:0] = mode_q;
         REG_PENDING: rdata[NUM_SRC-1:0] = pend_q;
         REG_RAW:     rdata[NUM_SRC-1:0] = s;
         REG_FORCE:   rdata = '0;
         default:     hit = 1'b0;
      endcase
   end

   assign PRDATA  = (access && hit) ? rdata : '0;
   assign PSLVERR = access & ~hit;

   // Edge bits: set beats W1C; level bits follow s; a MODE change clears last and wins.
   always_comb begin
      set_bits = rise | ((wr && word == REG_FORCE) ? wdata : '0);
      w1c_bits = (wr && word == REG_PENDING) ? wdata : '0;
      mode_chg = (wr && word == REG_MODE) ? (wdata ^ mode_q) : '0;
      pend_d   = (mode_q & (set_bits | (pend_q & ~w1c_bits))) | (~mode_q & s);
      pend_d   = pend_d & ~mode_chg;
      irq_d    = '0;
      irq_d[NUM_SRC-1:0] = pend_q & enable_q;
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         hist_q   <= '0;
         enable_q <= '0;
         mode_q   <= MODE_DEFAULT;
         pend_q   <= '0;
         IRQ_OUT  <= '0;
         IRQ_ANY  <= 1'b0;
      end else begin
         sync_q[0] <= SRC_IRQ;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         hist_q  <= s;
         pend_q  <= pend_d;
         IRQ_OUT <= irq_d;
         IRQ_ANY <= |irq_d;
         if (wr && word == REG_ENABLE) enable_q <= wdata;
         if (wr && word == REG_MODE)   mode_q   <= wdata;
      end
   end

endmodule

// File: tb/tb_irq_aggregator.sv
// Bench for irq_aggregator: directed sequences, a register vector table and
// randomized traffic against a queue-based reference model.
module tb_irq_aggregator;
   localparam int unsigned    NS       = 8;
   localparam int unsigned    SS       = 2;
   localparam logic [NS-1:0]  MODE_DEF = 8'h30;

   logic          CLK = 1'b0;
   logic          RESETN;
   logic [NS-1:0] SRC_IRQ;
   logic          PSEL, PENABLE, PWRITE;
   logic [7:0]    PADDR;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA;
   logic          PREADY, PSLVERR;
   logic [30:0]   IRQ_OUT;
   logic          IRQ_ANY;

   int vectors     = 0;
   int miscompares = 0;
   logic model_chk = 1'b0;

   irq_aggregator #(.NUM_SRC(NS), .SYNC_STAGES(SS), .MODE_DEFAULT(MODE_DEF)) dut (
      .CLK(CLK), .RESETN(RESETN), .SRC_IRQ(SRC_IRQ), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .IRQ_OUT(IRQ_OUT), .IRQ_ANY(IRQ_ANY));

   always #5 CLK = ~CLK;

   // Reference model: source history as a queue, pending decided bit by bit from the rules.
   logic [NS-1:0] m_en, m_mode, m_pend, m_prevs;
   logic [30:0]   m_irq;
   logic          m_any;
   logic [NS-1:0] src_q [$];

   task automatic model_step();
      logic [NS-1:0] sv, rise, nxt;
      logic          w;
      logic [5:0]    a;
      if (!RESETN) begin
         m_en = '0; m_mode = MODE_DEF; m_pend = '0; m_prevs = '0; m_irq = '0; m_any = 1'b0;
         src_q.delete();
         for (int i = 0; i < int'(SS); i++) src_q.push_back('0);
      end else begin
         sv    = src_q[SS-1];
         rise  = sv & ~m_prevs;
         w     = PSEL && PENABLE && PWRITE;
         a     = PADDR[7:2];
         m_irq = 31'(m_pend & m_en);
         m_any = (m_irq != 0);
         for (int i = 0; i < int'(NS); i++) begin
            if (w && a == 1 && PWDATA[i] != m_mode[i]) nxt[i] = 1'b0;
            else if (!m_mode[i])                          nxt[i] = sv[i];
            else if (rise[i] || (w && a == 4 && PWDATA[i])) nxt[i] = 1'b1;
            else if (w && a == 2 && PWDATA[i])            nxt[i] = 1'b0;
            else                                          nxt[i] = m_pend[i];
         end
         m_pend = nxt;
         if (w && a == 0) m_en   = PWDATA[NS-1:0];
         if (w && a == 1) m_mode = PWDATA[NS-1:0];
         m_prevs = sv;
         src_q.push_front(SRC_IRQ);
         void'(src_q.pop_back());
      end
   endtask

   function automatic void model_read(input logic [7:0] a, output logic [31:0] rd, output logic err);
      logic [5:0] wa;
      wa = a[7:2];
      rd = '0; err = 1'b0;
      case (wa)
         6'd0:    rd = 32'(m_en);
         6'd1:    rd = 32'(m_mode);
         6'd2:    rd = 32'(m_pend);
         6'd3:    rd = 32'(src_q[SS-1]);
         6'd4:    rd = '0;
         default: err = 1'b1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK) begin
      model_step();
      if (model_chk) begin
         #1;
         check("rand_irq_out", 32'(IRQ_OUT), 32'(m_irq));
         check("rand_irq_any", 32'(IRQ_ANY), 32'(m_any));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
      logic [31:0] erd;
      logic        eerr;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      #1;
      if (model_chk) begin
         check("setup_prdata", PRDATA, 32'h0);
         check("setup_pslverr", 32'(PSLVERR), 32'h0);
      end
      tick();
      PENABLE = 1'b1;
      #1;
      rd = PRDATA; err = PSLVERR;
      if (model_chk) begin
         model_read(a, erd, eerr);
         check("rand_pslverr", 32'(err), 32'(eerr));
         if (!wr) check("rand_prdata", rd, erd);
      end
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   typedef struct {
      logic          wr;
      logic [7:0]    addr;
      logic [31:0]   wdata;
      logic [NS-1:0] src;
      logic [31:0]   exp_rd;
      logic          exp_err;
   } vec_t;

   vec_t        tbl [14];
   logic [31:0] rd;
   logic        err;
   logic [7:0]  addrs [7];

   initial begin
      RESETN = 1'b0; SRC_IRQ = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
      tbl[0]  = '{0, 8'h14, 32'h0,        8'h00, 32'h0,  1'b1};
      tbl[1]  = '{1, 8'h14, 32'hFFFFFFFF, 8'h00, 32'h0,  1'b1};
      tbl[2]  = '{1, 8'h00, 32'hFFFFFFFF, 8'h00, 32'h0,  1'b0};
      tbl[3]  = '{0, 8'h00, 32'h0,        8'h00, 32'hFF, 1'b0};
      tbl[4]  = '{0, 8'h03, 32'h0,        8'h00, 32'hFF, 1'b0};
      tbl[5]  = '{1, 8'h04, 32'hFFFFFFA5, 8'h00, 32'h0,  1'b0};
      tbl[6]  = '{0, 8'h04, 32'h0,        8'h00, 32'hA5, 1'b0};
      tbl[7]  = '{0, 8'h10, 32'h0,        8'h00, 32'h0,  1'b0};
      tbl[8]  = '{0, 8'h0C, 32'h0,        8'h5A, 32'h5A, 1'b0};
      tbl[9]  = '{0, 8'h08, 32'h0,        8'h5A, 32'h5A, 1'b0};
      tbl[10] = '{1, 8'h08, 32'hFF,       8'h5A, 32'h0,  1'b0};
      tbl[11] = '{0, 8'h08, 32'h0,        8'h5A, 32'h5A, 1'b0};
      tbl[12] = '{0, 8'hFC, 32'h0,        8'h5A, 32'h0,  1'b1};
      tbl[13] = '{0, 8'h17, 32'h0,        8'h5A, 32'h0,  1'b1};

      // Reset state
      repeat (3) tick();
      check("reset_irq_out", 32'(IRQ_OUT), 32'h0);
      check("reset_irq_any", 32'(IRQ_ANY), 32'h0);
      RESETN = 1'b1;
      tick();
      xfer(0, 8'h04, 0, rd, err); check("reset_mode", rd, 32'(MODE_DEF));
      xfer(0, 8'h00, 0, rd, err); check("reset_enable", rd, 32'h0);

      // Edge source latency and W1C
      xfer(1, 8'h00, 32'h01, rd, err);
      xfer(1, 8'h04, 32'h01, rd, err);
      SRC_IRQ[0] = 1'b1;
      tick(); tick();
      check("edge_k1", 32'(IRQ_OUT), 32'h0);
      tick();
      check("edge_k2", 32'(IRQ_OUT), 32'h0);
      tick();
      check("edge_k3_out", 32'(IRQ_OUT), 32'h1);
      check("edge_k3_any", 32'(IRQ_ANY), 32'h1);
      xfer(0, 8'h08, 0, rd, err); check("edge_pending", rd, 32'h1);
      xfer(1, 8'h08, 32'h01, rd, err);
      check("w1c_same_edge", 32'(IRQ_OUT), 32'h1);
      tick();
      check("w1c_cleared", 32'(IRQ_OUT), 32'h0);
      check("w1c_any", 32'(IRQ_ANY), 32'h0);
      repeat (4) tick();
      check("held_high_one_event", 32'(IRQ_OUT), 32'h0);
      SRC_IRQ[0] = 1'b0;

      // Level source
      xfer(1, 8'h00, 32'h08, rd, err);
      xfer(1, 8'h04, 32'h00, rd, err);
      SRC_IRQ[3] = 1'b1;
      repeat (10) tick();
      check("level_high", 32'(IRQ_OUT), 32'h08);
      xfer(1, 8'h08, 32'h08, rd, err);
      tick();
      check("level_w1c_ignored", 32'(IRQ_OUT), 32'h08);
      xfer(0, 8'h08, 0, rd, err); check("level_pending", rd, 32'h08);
      SRC_IRQ[3] = 1'b0;
      tick(); tick();
      check("level_drop_k1", 32'(IRQ_OUT), 32'h08);
      tick(); tick();
      check("level_drop_k3", 32'(IRQ_OUT), 32'h0);

      // Set beats W1C, FORCE, enable masking, MODE-change clear
      xfer(1, 8'h04, 32'h06, rd, err);
      xfer(1, 8'h00, 32'h06, rd, err);
      SRC_IRQ[1] = 1'b1;
      tick();
      xfer(1, 8'h08, 32'h02, rd, err);
      xfer(0, 8'h08, 0, rd, err); check("set_beats_w1c", rd, 32'h02);
      xfer(1, 8'h10, 32'h0C, rd, err);
      xfer(0, 8'h08, 0, rd, err); check("force_edge_only", rd, 32'h06);
      xfer(0, 8'h10, 0, rd, err); check("force_reads_0", rd, 32'h0);
      check("force_irq_out", 32'(IRQ_OUT), 32'h06);
      xfer(1, 8'h00, 32'h00, rd, err);
      tick();
      check("mask_irq_out", 32'(IRQ_OUT), 32'h0);
      xfer(0, 8'h08, 0, rd, err); check("mask_keeps_pending", rd, 32'h06);
      xfer(1, 8'h00, 32'h06, rd, err);
      check("reenable_same_edge", 32'(IRQ_OUT), 32'h0);
      tick();
      check("reenable_next", 32'(IRQ_OUT), 32'h06);
      xfer(1, 8'h04, 32'h02, rd, err);
      xfer(0, 8'h08, 0, rd, err); check("mode_change_clear", rd, 32'h02);
      SRC_IRQ = '0;

      // Register table
      RESETN = 1'b0; tick(); tick(); RESETN = 1'b1; tick();
      for (int i = 0; i < 14; i++) begin
         SRC_IRQ = tbl[i].src;
         repeat (SS) tick();
         xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err);
         check($sformatf("tbl%0d_pslverr", i), 32'(err), 32'(tbl[i].exp_err));
         if (!tbl[i].wr) check($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
      end
      tick();
      check("tbl_irq_out", 32'(IRQ_OUT), 32'h5A);

      // Reset during a write access phase
      SRC_IRQ = '0;
      repeat (4) tick();
      xfer(1, 8'h04, 32'hFF, rd, err);
      xfer(1, 8'h10, 32'hFF, rd, err);
      xfer(0, 8'h08, 0, rd, err); check("pre_reset_pending", rd, 32'hFF);
      check("pre_reset_irq", 32'(IRQ_OUT), 32'hFF);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h0F;
      tick();
      PENABLE = 1'b1; RESETN = 1'b0;
      tick();
      check("rst_access_irq", 32'(IRQ_OUT), 32'h0);
      check("rst_access_any", 32'(IRQ_ANY), 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; RESETN = 1'b1;
      tick();
      xfer(0, 8'h08, 0, rd, err); check("rst_access_pending", rd, 32'h0);
      xfer(0, 8'h04, 0, rd, err); check("rst_access_mode", rd, 32'(MODE_DEF));

      // Randomized traffic against the model
      addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08; addrs[3] = 8'h0C;
      addrs[4] = 8'h10; addrs[5] = 8'h14; addrs[6] = 8'h40;
      model_chk = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) SRC_IRQ = NS'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            RESETN = 1'b0; tick(); RESETN = 1'b1;
         end else if ($urandom_range(0, 2) == 0) begin
            tick();
         end else begin
            xfer(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 6)], $urandom, rd, err);
         end
      end
      tick();
      model_chk = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
